sram_port_arbiter: RTL and testbench

- Shares one single-ported SRAM/bus port between the instruction-fetch requester (read-only) and the memory-access stage requester (load/store, byte-masked).
- Sits between the IF/MEM stages and the external memory interface.
- Registers the granted request, tracks one outstanding transaction, and routes the response back to its owner.
- Generates per-requester stall outputs so the pipeline holds while its access is pending.

---
 rtl/core_pkg.sv | 30 +++
 rtl/fixed_prio_starve_guard.sv | 48 ++++
 rtl/sram_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_sram_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types for the SRAM port arbiter.
//   arb_state_e : arbiter FSM states
//   owner_e     : which requester owns the outstanding transaction
//   mem_req_t   : registered downstream request (sized by the CORE_* widths;
//                 the arbiter width parameters default to these values)
package core_pkg;

  localparam int CORE_ADDR_W = 32;
  localparam int CORE_DATA_W = 32;
  localparam int CORE_MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  typedef struct packed {
    logic                   we;
    logic [CORE_ADDR_W-1:0] addr;
    logic [CORE_DATA_W-1:0] wdata;
    logic [CORE_MASK_W-1:0] wmask;
  } mem_req_t;

endpackage

// File: rtl/fixed_prio_starve_guard.sv
// Fixed-priority (data over fetch) winner select with a starvation guard.
//   clk, rst_n : clock, async active-low reset
//   arb_en     : arbitration allowed this cycle (arbiter idle)
//   if_req     : fetch request
//   d_req      : data request
//   if_win     : fetch wins this cycle (combinational)
//   d_win      : data wins this cycle (combinational)
// A streak counter tracks data grants made while a fetch was waiting; once it
// reaches STREAK_MAX the waiting fetch is forced through.
module fixed_prio_starve_guard #(
  parameter int STREAK_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en,
  input  logic if_req,
  input  logic d_req,
  output logic if_win,
  output logic d_win
);

  localparam logic [2:0] STREAK_LIM = 3'(STREAK_MAX);

  logic [2:0] streak_cnt;
  logic       force_if;

  always_comb begin
    force_if = if_req && (streak_cnt == STREAK_LIM);
    d_win    = arb_en && d_req && !force_if;
    if_win   = arb_en && if_req && !d_win;
  end

  // Only data grants with a fetch waiting lengthen the streak; anything else
  // means fetch is not being starved, so the streak restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_cnt <= '0;
    end else if (if_win) begin
      streak_cnt <= '0;
    end else if (d_win) begin
      if (!if_req)
        streak_cnt <= '0;
      else if (streak_cnt != STREAK_LIM)
        streak_cnt <= streak_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-ported SRAM/bus port between instruction fetch (read
// only) and the memory stage (load/store, byte-masked). One transaction is
// outstanding at a time: IDLE (arbitrate + latch) -> ISSUE (mem_req until
// mem_ready) -> WAIT (until mem_rvalid) -> IDLE.
//   clk, rst_n                       : clock, async active-low reset
//   if_req/if_addr/if_gnt            : fetch request side
//   if_rvalid/if_rdata               : fetch response (registered pulse)
//   d_req/d_we/d_addr/d_wdata/d_wmask/d_gnt : data request side
//   d_rvalid/d_rdata                 : load data / store ack (registered pulse)
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wmask/mem_ready : downstream request
//   mem_rvalid/mem_rdata             : downstream response
//   stall_if/stall_mem               : hold the requesting stage
module sram_port_arbiter import core_pkg::*; #(
  parameter int ADDR_W     = CORE_ADDR_W,
  parameter int DATA_W     = CORE_DATA_W,
  parameter int MASK_W     = CORE_MASK_W,
  parameter int STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [MASK_W-1:0] d_wmask,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  arb_state_e state, state_nxt;
  owner_e     owner_q;
  mem_req_t   req_q;
  logic       arb_en;
  logic       if_win, d_win;
  logic       if_pend, d_pend;

  // Grants are combinational; gating with rst_n keeps them low while reset
  // is held even if a requester is already asserting.
  assign arb_en = rst_n && (state == IDLE);

  fixed_prio_starve_guard #(
    .STREAK_MAX (STREAK_MAX)
  ) u_guard (
    .clk    (clk),
    .rst_n  (rst_n),
    .arb_en (arb_en),
    .if_req (if_req),
    .d_req  (d_req),
    .if_win (if_win),
    .d_win  (d_win)
  );

  assign if_gnt = if_win;
  assign d_gnt  = d_win;

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (if_win || d_win) state_nxt = ISSUE;
      ISSUE:   if (mem_ready)       state_nxt = WAIT;
      WAIT:    if (mem_rvalid)      state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Request register: the downstream port is driven only from here, so no
  // requester input has a combinational path to mem_*. Write data and mask
  // are zeroed for anything that is not a store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      owner_q <= OWN_IF;
    end else if (d_win) begin
      owner_q     <= OWN_D;
      req_q.we    <= d_we;
      req_q.addr  <= d_addr;
      req_q.wdata <= d_we ? d_wdata : '0;
      req_q.wmask <= d_we ? d_wmask : '0;
    end else if (if_win) begin
      owner_q     <= OWN_IF;
      req_q.we    <= 1'b0;
      req_q.addr  <= if_addr;
      req_q.wdata <= '0;
      req_q.wmask <= '0;
    end
  end

  assign mem_req   = (state == ISSUE);
  assign mem_we    = req_q.we;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign mem_wmask = req_q.wmask;

  // Response routing. mem_rvalid outside WAIT (stray, or a leftover from a
  // transaction abandoned by reset) is dropped. Store acks leave d_rdata alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if (state == WAIT && mem_rvalid) begin
        if (owner_q == OWN_IF) begin
          if_rvalid <= 1'b1;
          if_rdata  <= mem_rdata;
        end else begin
          d_rvalid <= 1'b1;
          if (!req_q.we) d_rdata <= mem_rdata;
        end
      end
    end
  end

  // Pending flags carry the stall past the grant, after the requester has
  // dropped its req. A grant on the rvalid cycle (back-to-back) re-arms it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_pend <= 1'b0;
      d_pend  <= 1'b0;
    end else begin
      if (if_gnt)         if_pend <= 1'b1;
      else if (if_rvalid) if_pend <= 1'b0;
      if (d_gnt)          d_pend  <= 1'b1;
      else if (d_rvalid)  d_pend  <= 1'b0;
    end
  end

  assign stall_if  = rst_n && (if_req || if_pend) && !if_rvalid;
  assign stall_mem = rst_n && (d_req  || d_pend)  && !d_rvalid;

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_wmask;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall_if, stall_mem;

  sram_port_arbiter #(.STREAK_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Reference model state: streak length, last delivered read data per owner,
  // and the requests each side currently holds.
  int          m_streak;
  logic [31:0] m_if_rdata, m_d_rdata;
  bit          rv_if_now, rv_d_now;
  bit          p_if, p_d, p_we;
  logic [31:0] p_ia, p_da, p_wd;
  logic [3:0]  p_wm;
  logic [9:0]  order;
  logic [9:0]  exp_order;
  bit          won;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    rv_if_now = 1'b0;
    rv_d_now  = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk1 (tag, mem_req, 1'b0);
    chk1 (tag, mem_we, 1'b0);
    chk32(tag, mem_addr, 32'h0);
    chk32(tag, mem_wdata, 32'h0);
    chk32(tag, {28'h0, mem_wmask}, 32'h0);
    chk1 (tag, if_gnt, 1'b0);
    chk1 (tag, d_gnt, 1'b0);
    chk1 (tag, if_rvalid, 1'b0);
    chk1 (tag, d_rvalid, 1'b0);
    chk32(tag, if_rdata, 32'h0);
    chk32(tag, d_rdata, 32'h0);
    chk1 (tag, stall_if, 1'b0);
    chk1 (tag, stall_mem, 1'b0);
  endtask

  // One full access from the IDLE cycle to the rvalid cycle, with the
  // expected winner and downstream fields derived from the held requests.
  task automatic do_txn(input int rdy_dly, input int rv_dly,
                        input logic [31:0] rdata, output bit won_d);
    bit          exp_d;
    logic        ewe;
    logic [31:0] eaddr, ewd;
    logic [3:0]  ewm;
    if_req = p_if; if_addr = p_ia;
    d_req = p_d; d_we = p_we; d_addr = p_da; d_wdata = p_wd; d_wmask = p_wm;
    #2;
    exp_d = p_d && !(p_if && m_streak == SMAX);
    won_d = exp_d;
    chk1("if_gnt", if_gnt, !exp_d);
    chk1("d_gnt", d_gnt, exp_d);
    chk1("stall_if_req", stall_if, p_if && !rv_if_now);
    chk1("stall_mem_req", stall_mem, p_d && !rv_d_now);
    if (exp_d) begin
      ewe = p_we; eaddr = p_da;
      ewd = p_we ? p_wd : 32'h0;
      ewm = p_we ? p_wm : 4'h0;
      m_streak = p_if ? ((m_streak < SMAX) ? m_streak + 1 : SMAX) : 0;
    end else begin
      ewe = 1'b0; eaddr = p_ia; ewd = 32'h0; ewm = 4'h0;
      m_streak = 0;
    end
    tick;
    if (exp_d) begin p_d = 1'b0; d_req = 1'b0; end
    else       begin p_if = 1'b0; if_req = 1'b0; end
    for (int k = 0; k <= rdy_dly; k++) begin
      mem_ready = (k == rdy_dly);
      #2;
      chk1 ("issue_mem_req", mem_req, 1'b1);
      chk1 ("issue_mem_we", mem_we, ewe);
      chk32("issue_mem_addr", mem_addr, eaddr);
      chk32("issue_mem_wdata", mem_wdata, ewd);
      chk32("issue_mem_wmask", {28'h0, mem_wmask}, {28'h0, ewm});
      chk1 ("issue_no_gnt", if_gnt || d_gnt, 1'b0);
      chk1 ("issue_stall_own", exp_d ? stall_mem : stall_if, 1'b1);
      chk1 ("issue_stall_other", exp_d ? stall_if : stall_mem, exp_d ? p_if : p_d);
      tick;
    end
    mem_ready = 1'b0;
    for (int k = 0; k <= rv_dly; k++) begin
      mem_rvalid = (k == rv_dly);
      mem_rdata  = (k == rv_dly) ? rdata : 32'($urandom);
      #2;
      chk1("wait_mem_req", mem_req, 1'b0);
      chk1("wait_no_gnt", if_gnt || d_gnt, 1'b0);
      chk1("wait_no_rvalid", if_rvalid || d_rvalid, 1'b0);
      chk1("wait_stall_own", exp_d ? stall_mem : stall_if, 1'b1);
      tick;
    end
    mem_rvalid = 1'b0;
    mem_rdata  = 32'($urandom);
    if (exp_d) begin
      if (!ewe) m_d_rdata = rdata;
    end else begin
      m_if_rdata = rdata;
    end
    #2;
    chk1 ("if_rvalid", if_rvalid, !exp_d);
    chk1 ("d_rvalid", d_rvalid, exp_d);
    chk32("if_rdata", if_rdata, m_if_rdata);
    chk32("d_rdata", d_rdata, m_d_rdata);
    chk1 ("rv_stall_own", exp_d ? stall_mem : stall_if, 1'b0);
    rv_if_now = !exp_d;
    rv_d_now  = exp_d;
  endtask

  task automatic new_reqs;
    if (!p_if && $urandom_range(0, 1) == 1) begin
      p_if = 1'b1;
      p_ia = 32'($urandom) & 32'hFFFF_FFFC;
    end
    if (!p_d && ($urandom_range(0, 1) == 1 || !p_if)) begin
      p_d  = 1'b1;
      p_we = 1'($urandom_range(0, 1));
      p_da = 32'($urandom) & 32'hFFFF_FFFC;
      p_wd = 32'($urandom);
      p_wm = 4'($urandom_range(1, 15));
    end
  endtask

  initial begin
    m_streak = 0; m_if_rdata = 32'h0; m_d_rdata = 32'h0;
    rv_if_now = 1'b0; rv_d_now = 1'b0;
    p_if = 1'b0; p_d = 1'b0; p_we = 1'b0;
    p_ia = 32'h0; p_da = 32'h0; p_wd = 32'h0; p_wm = 4'h0;
    order = '0;

    // Reset with both requesters already asserting
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wmask = 4'h0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #12;
    chk_zero("reset");
    if_req = 1'b0; d_req = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;

    // Single fetch
    p_if = 1'b1; p_ia = 32'h1C00_0000;
    do_txn(0, 0, 32'h0280_0413, won);

    // Store
    p_d = 1'b1; p_we = 1'b1; p_da = 32'h0000_0100; p_wd = 32'h0000_AB00; p_wm = 4'b0010;
    do_txn(0, 1, 32'h1234_5678, won);

    // Backpressure on a load
    p_d = 1'b1; p_we = 1'b0; p_da = 32'h0000_0204; p_wd = 32'hFFFF_FFFF; p_wm = 4'hF;
    do_txn(5, 0, 32'hCAFE_0001, won);

    // Stray response while idle
    tick;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #2;
    tick;
    mem_rvalid = 1'b0;
    #2;
    chk1 ("stray_if_rvalid", if_rvalid, 1'b0);
    chk1 ("stray_d_rvalid", d_rvalid, 1'b0);
    chk32("stray_if_rdata", if_rdata, m_if_rdata);
    chk32("stray_d_rdata", d_rdata, m_d_rdata);

    // Contention: both sides always requesting
    for (int i = 0; i < 10; i++) begin
      if (!p_if) begin p_if = 1'b1; p_ia = 32'h1000_0000 + 32'(i * 4); end
      if (!p_d) begin
        p_d = 1'b1; p_we = 1'($urandom_range(0, 1)); p_da = 32'h0000_0400 + 32'(i * 4);
        p_wd = 32'($urandom); p_wm = 4'hF;
      end
      do_txn(0, 0, 32'($urandom), won);
      order[i] = won;
    end
    exp_order = 10'b01_1110_1111;
    chk32("grant_order", {22'h0, order}, {22'h0, exp_order});

    // Reset while a load waits for its response
    tick;
    p_if = 1'b0; p_d = 1'b0;
    if_req = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
    #2;
    tick;
    d_req = 1'b0;
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    m_streak = 0; m_if_rdata = 32'h0; m_d_rdata = 32'h0;
    chk_zero("reset_in_wait");
    tick;
    rst_n = 1'b1;
    tick;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    #2;
    tick;
    mem_rvalid = 1'b0;
    #2;
    chk1 ("late_if_rvalid", if_rvalid, 1'b0);
    chk1 ("late_d_rvalid", d_rvalid, 1'b0);
    chk32("late_if_rdata", if_rdata, 32'h0);
    chk32("late_d_rdata", d_rdata, 32'h0);
    chk1 ("late_mem_req", mem_req, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      new_reqs();
      do_txn($urandom_range(0, 3), $urandom_range(0, 3), 32'($urandom), won);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
